// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit beside the ALU; owns HI/LO and stalls
// the pipeline while a MULT/DIV is in flight.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall
);

  // state | meaning
  // IDLE  | accepts MULT/DIV and MTHI/MTLO
  // CALC  | one shift-add or restoring-divide iteration per cycle
  // FIX   | sign correction and HI/LO write-back
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_b;
  logic                 r_is_div, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_done, r_dbz;

  logic                 w_accept, w_md_go, w_mt_go, w_signed, w_div_zero;
  logic [WIDTH-1:0]     w_abs1, w_abs2;
  logic [WIDTH:0]       w_msum, w_dtrial;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix, w_rem_fix, w_fix_hi, w_fix_lo;

  assign w_accept   = start & ~flush & (r_state == S_IDLE);
  assign w_md_go    = w_accept & ~op[2];
  assign w_mt_go    = w_accept & op[2] & ~op[1];
  assign w_signed   = ~op[0];
  assign w_div_zero = op[1] & (data2 == '0);
  assign w_abs1     = (w_signed & data1[WIDTH-1]) ? -data1 : data1;
  assign w_abs2     = (w_signed & data2[WIDTH-1]) ? -data2 : data2;

  // Multiply: low half holds the multiplier, consumed LSB first.
  assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
  assign w_mul_nxt = r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts the
  // dividend out and the quotient in.
  assign w_dtrial  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
  assign w_div_nxt = w_dtrial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_dtrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_fix_lo   = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_md_go) w_state_nxt = w_div_zero ? S_FIX : S_CALC;
      S_CALC: begin
        if (flush)                               w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))     w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX) & ~flush;
      case (r_state)
        S_IDLE: begin
          if (w_md_go) begin
            r_is_div <= op[1];
            r_cnt    <= '0;
            r_dbz    <= w_div_zero;
            // A zero divisor goes straight to FIX with the result preloaded.
            r_neg_q  <= w_signed & (data1[WIDTH-1] ^ data2[WIDTH-1]) & ~w_div_zero;
            r_neg_r  <= w_signed & data1[WIDTH-1] & ~w_div_zero;
            if (op[1]) begin
              r_b   <= w_abs2;
              r_acc <= w_div_zero ? {data1, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_abs1};
            end else begin
              r_b   <= w_abs1;
              r_acc <= {{WIDTH{1'b0}}, w_abs2};
            end
          end else if (w_mt_go) begin
            if (op[0]) r_lo <= data1;
            else       r_hi <= data1;
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign stall       = busy & (start | rd_hilo);

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU. Operands come from the ID/EX register-file read data.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, and owns the architectural HI/LO registers.
- Also handles MTHI and MTLO writes.
- Drives a stall request to the hazard unit, so that a new mult/div or an mfhi/mflo cannot proceed while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
start  input  1  request from EX; qualified by op
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
data1  input  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source)
data2  input  WIDTH  rt operand (multiplier / divisor)
rd_hilo  input  1  EX holds mfhi/mflo this cycle
flush  input  1  pipeline flush; aborts an in-flight operation
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse after HI/LO written by a mult/div
div_by_zero  output  1  sticky flag, set by DIV/DIVU with data2==0, cleared by next accepted mult/div
stall  output  1  combinational: busy & (start | rd_hilo)

Behaviour:
- Reset (async, any state): hi=0, lo=0, state=IDLE, counter=0, done=0, div_by_zero=0, internal datapath regs=0.
- States: IDLE, CALC, FIX.
- IDLE, start with op 100/101: hi or lo <= data1 on that edge; one cycle, busy stays 0, no done pulse.
- IDLE, start with op 000-011 (edge E0):
  - Latch op.
  - Latch |data1| and |data2| for signed ops (raw values for unsigned).
  - Latch result-sign bits: product sign = data1[31]^data2[31]; quotient same; remainder sign = data1[31].
  - counter <= 0; -> CALC; clear div_by_zero.
- Divide with data2==0 at E0: -> FIX directly (skip CALC); set div_by_zero. Result: hi<=data1, lo<={WIDTH{1'b1}}.
- CALC:
  - One iteration per cycle, WIDTH cycles (E1..E32 for WIDTH=32).
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle, MSB first.
  - At counter==WIDTH-1 -> FIX.
- FIX (one edge, E33):
  - Apply two's-complement sign correction (signed ops only).
  - Multiply: hi<=product[2W-1:W], lo<=product[W-1:0].
  - Divide: lo<=quotient, hi<=remainder.
  - -> IDLE; done=1 for the following cycle only.
- Latency: busy high from after E0 through E33 (33 cycles); new HI/LO visible after E33. Divide-by-zero takes 2 edges.
- Arithmetic is modulo 2^WIDTH, with no overflow trap:
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- Remainder sign follows the dividend; quotient truncates toward zero.
- start while busy: ignored (no relatch). The pipeline holds via stall and re-presents the request after IDLE.
- MTHI/MTLO while busy: ignored; stall is asserted, so the pipeline retries.
- flush while busy:
  - Next edge -> IDLE; hi/lo unchanged; no done pulse; div_by_zero unchanged.
  - flush and start together in IDLE: start is ignored.
- hi/lo change only on MTHI/MTLO, FIX, or reset. They are stable and readable while busy; the consumer must honour stall.
- done and FIX never coincide with an MTHI/MTLO write, because MTHI/MTLO is only accepted in IDLE.

Test Plan:
1. MULT data1=0xFFFFFFFD (-3), data2=7 -> after 33 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once; MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
2. DIV data1=0xFFFFFFF9 (-7), data2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIVU data1=0x1234, data2=0 -> busy exactly 1 cycle; hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1; next MULT 2*3 clears it, lo=6.
4. Start MULT 5*5, assert rd_hilo at cycle 10 -> stall=1 until FIX edge, hi/lo unchanged (old values) until E33, then lo=25; a second start at cycle 5 is ignored (result still 25).
5. MTHI 0xAAAA0000 then MTLO 0x5555 in consecutive idle cycles -> hi=0xAAAA0000, lo=0x5555, busy never high; MTLO issued while busy -> stall=1, lo unchanged.
6. Start DIV, assert flush at cycle 12 -> IDLE next edge, no done, hi/lo keep prior values; assert rst at cycle 20 of another MULT -> hi=lo=0, busy=0 immediately (asynchronous).
